// File: rtl/pla_cube_scheduler.sv
// Time-multiplexed PLA sum-of-products evaluator: one shared matcher walks the cube table.
// Optional PLA_CUBE_SCHED_EARLY_EXIT_EN ends the scan on the first matching cube.

module pla_cube_match #(
  parameter int NIN = 12
) (
  input  logic [NIN-1:0] x,
  input  logic [NIN-1:0] care,
  input  logic [NIN-1:0] val,
  input  logic           en,
  output logic           hit
);
  assign hit = en && (((x ^ val) & care) == '0);
endmodule

module pla_cube_scheduler #(
  parameter  int NIN    = 12,
  parameter  int NCUBES = 8,
  localparam int IDXW   = $clog2(NCUBES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_addr,
  input  logic [NIN-1:0]  cfg_care,
  input  logic [NIN-1:0]  cfg_val,
  input  logic            cfg_en,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NIN-1:0]  in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_y,
  output logic [IDXW-1:0] out_idx,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef struct packed {
    logic [NIN-1:0] care;
    logic [NIN-1:0] val;
    logic           en;
  } cube_t;

  state_t          state, state_nxt;
  cube_t           tbl [NCUBES];
  cube_t           cur;
  logic [NIN-1:0]  xr;
  logic [IDXW-1:0] ptr, acc_idx;
  logic            acc_y, hit, last, done_now;

  assign cur  = tbl[ptr];
  assign last = (ptr == IDXW'(NCUBES - 1));

  pla_cube_match #(.NIN(NIN)) u_match (
    .x(xr), .care(cur.care), .val(cur.val), .en(cur.en), .hit(hit)
  );

`ifdef PLA_CUBE_SCHED_EARLY_EXIT_EN
  assign done_now = hit || last;
`else
  assign done_now = last;
`endif

  assign in_ready  = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (done_now) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table writes only land in IDLE, so a scan always sees one consistent table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCUBES; k++) tbl[k] <= '0;
    end else if (state == IDLE && cfg_we && int'(cfg_addr) < NCUBES) begin
      tbl[cfg_addr] <= '{care: cfg_care, val: cfg_val, en: cfg_en};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr      <= '0;
      ptr     <= '0;
      acc_y   <= 1'b0;
      acc_idx <= '0;
      out_y   <= 1'b0;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr      <= in_x;
          ptr     <= '0;
          acc_y   <= 1'b0;
          acc_idx <= '0;
        end
        SCAN: begin
          ptr <= last ? '0 : ptr + IDXW'(1);
          if (hit && !acc_y) begin
            acc_y   <= 1'b1;
            acc_idx <= ptr;
          end
          // Fold in this cycle's hit since acc_* only update at the same edge.
          if (done_now) begin
            out_y   <= acc_y | hit;
            out_idx <= acc_y ? acc_idx : (hit ? ptr : '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pla_cube_scheduler.sv
// Directed bench for pla_cube_scheduler with a table-level reference model and per-cycle compare.
module tb_pla_cube_scheduler;
  localparam int NIN = 12, NCUBES = 8, IDXW = 3;

  logic            clk = 0, rst = 1;
  logic            cfg_we = 0, cfg_en = 0, in_valid = 0, out_ready = 0;
  logic [IDXW-1:0] cfg_addr = '0;
  logic [NIN-1:0]  cfg_care = '0, cfg_val = '0, in_x = '0;
  logic            cfg_ready, in_ready, out_valid, out_y, busy;
  logic [IDXW-1:0] out_idx;

  pla_cube_scheduler #(.NIN(NIN), .NCUBES(NCUBES)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_en(cfg_en), .cfg_ready(cfg_ready), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [NIN-1:0] m_care [NCUBES];
  logic [NIN-1:0] m_val  [NCUBES];
  logic           m_en   [NCUBES];
  logic           exp_y;
  logic [IDXW-1:0] exp_idx;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Lowest enabled cube whose cared literals all equal the required values.
  task automatic model_eval(input logic [NIN-1:0] x, output logic y, output logic [IDXW-1:0] idx);
    y = 0; idx = '0;
    for (int k = NCUBES - 1; k >= 0; k--)
      if (m_en[k] && ((x & m_care[k]) == (m_val[k] & m_care[k]))) begin
        y = 1; idx = IDXW'(k);
      end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCUBES; k++) begin m_care[k] = '0; m_val[k] = '0; m_en[k] = 0; end
  endtask

  function automatic int model_lat(input logic y, input logic [IDXW-1:0] idx);
`ifdef PLA_CUBE_SCHED_EARLY_EXIT_EN
    return y ? int'(idx) + 2 : NCUBES + 1;
`else
    return NCUBES + 1;
`endif
  endfunction

  always @(negedge clk) if (chk_en && !rst) begin
    check("in_ready_vs_busy", in_ready, !busy);
    check("cfg_ready_vs_in_ready", cfg_ready, in_ready);
    if (out_valid) begin
      check("out_y", out_y, exp_y);
      check("out_idx", out_idx, exp_idx);
      check("busy_in_done", busy, 1);
    end
  end

  task automatic cfg_write(input logic [IDXW-1:0] a, input logic [NIN-1:0] c, v, input logic e);
    @(negedge clk);
    check("cfg_ready_pre_write", cfg_ready, 1);
    cfg_we = 1; cfg_addr = a; cfg_care = c; cfg_val = v; cfg_en = e;
    @(posedge clk);
    m_care[a] = c; m_val[a] = v; m_en[a] = e;
    #1 cfg_we = 0;
  endtask

  // One operation; optional same-cycle write, optional dropped write during SCAN, DONE hold.
  task automatic run(input logic [NIN-1:0] x, input bit we, input logic [IDXW-1:0] a,
                     input logic [NIN-1:0] c, v, input logic e, input int hold, input bit midwr,
                     input logic ly, input logic [IDXW-1:0] li);
    int lat;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_x = x; in_valid = 1;
    cfg_we = we; cfg_addr = a; cfg_care = c; cfg_val = v; cfg_en = e;
    @(posedge clk);
    if (we) begin m_care[a] = c; m_val[a] = v; m_en[a] = e; end
    model_eval(x, exp_y, exp_idx);
    check("model_y_literal", exp_y, ly);
    check("model_idx_literal", exp_idx, li);
    lat = 1;
    @(negedge clk);
    cfg_we = 0;
    if (midwr) in_x = 12'hABC; else in_valid = 0;
    while (!out_valid) begin
      if (lat >= 40) begin check("out_valid_timeout", lat, model_lat(exp_y, exp_idx)); break; end
      if (midwr) begin
        check("in_ready_scan", in_ready, 0);
        cfg_we = (lat == 3); cfg_addr = 0; cfg_care = '0; cfg_val = '0; cfg_en = 1;
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    cfg_we = 0;
    check("latency", lat, model_lat(exp_y, exp_idx));
    check("out_y_literal", out_y, ly);
    check("out_idx_literal", out_idx, li);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1; in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    logic ty; logic [IDXW-1:0] ti;
    model_clear();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 0;
    @(negedge clk);
    check("rst_out_y", out_y, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    chk_en = 1;

    run(12'h0E3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg_write(3, 12'hFFF, 12'h0E3, 1);
    run(12'h0E3, 0, 0, 0, 0, 0, 1, 0, 1, 3);
    run(12'h0E2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cfg_write(2, 12'h000, 12'h000, 1);
    cfg_write(5, 12'h000, 12'h000, 1);
    run(12'h555, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    run(12'h0E3, 0, 0, 0, 0, 0, 2, 0, 1, 2);
    run(12'h3C0, 0, 0, 0, 0, 0, 5, 1, 1, 2);
    cfg_write(2, 12'h000, 12'h000, 0);
    cfg_write(5, 12'h000, 12'h000, 0);
    run(12'h0E2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(12'h001, 1, 1, 12'h001, 12'h001, 1, 0, 0, 1, 1);
    run(12'h0E3, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    run(12'h0E2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(12'hFFF, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Abort mid-scan with reset.
    @(negedge clk);
    in_x = 12'h0E3; in_valid = 1;
    @(posedge clk);
    @(negedge clk); in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_before_abort", busy, 1);
    chk_en = 0; rst = 1;
    model_clear();
    repeat (2) begin @(negedge clk); check("abort_out_valid", out_valid, 0); end
    rst = 0;
    @(posedge clk); @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid_post", out_valid, 0);
    check("abort_out_y", out_y, 0);
    chk_en = 1;
    model_eval(12'h001, ty, ti);
    check("model_cleared", ty, 0);
    run(12'h0E3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(12'h001, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d tests expected completion", tests);
    $fatal(1);
  end
endmodule

// File: doc/pla_cube_scheduler.md
Name: pla_cube_scheduler

Overview:
Time-multiplexed sum-of-products evaluator for restricted PLA functions. It holds a small table of cubes, each a care mask plus a polarity vector. A single shared cube-match datapath evaluates an accepted input vector against the table, one cube per cycle. The ORed result is returned with the index of the first matching cube. It sits between the benchmark stimulus source and the result checker, and replaces one AND-tree per cube with one sequenced matcher.

Parameters:
NIN, 12, input vector width (number of PLA literals x0..x(NIN-1)).
NCUBES, 8, number of cube table entries; must be >= 2.
IDXW, $clog2(NCUBES), cube index width; localparam, not overridable.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
cfg_we  input  1  cube table write strobe.
cfg_addr  input  IDXW  entry written.
cfg_care  input  NIN  care mask; bit=1 means the literal participates.
cfg_val  input  NIN  required literal value where care=1.
cfg_en  input  1  entry enable written with the entry.
cfg_ready  output  1  high only in IDLE; writes with cfg_ready low are dropped.
in_valid  input  1  input vector valid.
in_ready  output  1  scheduler accepts the vector.
in_x  input  NIN  input vector; bit i = x_i.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_y  output  1  OR over enabled cubes of the cube match.
out_idx  output  IDXW  lowest matching cube index; 0 when out_y=0.
busy  output  1  high in SCAN or DONE.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. Reset clears every table entry (care=0, val=0, en=0), state=IDLE, out_valid=0, out_y=0, out_idx=0, in_ready=1, cfg_ready=1, busy=0. Reset asserted mid-SCAN or mid-DONE aborts the operation and discards the result.
- Cube match for entry k: en[k] & (((x ^ val[k]) & care[k]) == 0). An enabled entry with care=0 matches every x.
- IDLE: in_ready=1, cfg_ready=1. A write when cfg_we=1 updates the entry at the clock edge. If in_valid=1 in the same cycle, the vector is captured into an internal register, the pointer ptr=0, acc_y=0 and state goes to SCAN. When cfg_we and in_valid are both high in the same IDLE cycle, the write takes effect first. The captured vector is then evaluated against the updated table.
- SCAN: in_ready=0, cfg_ready=0. Each cycle entry ptr is evaluated. On the first match, acc_y is set to 1 and acc_idx takes ptr; later matches do not change acc_idx. When ptr=NCUBES-1, the state goes to DONE and the accumulated values load out_y/out_idx. ptr wraps to 0 and is not reused.
- DONE: out_valid=1 and outputs are held stable. When out_ready=1, the state goes to IDLE and out_valid drops next cycle. Back-to-back operation: a new vector can be accepted at the earliest one cycle after the handshake.
- Latency: in handshake edge to out_valid = NCUBES+1 cycles (NCUBES SCAN cycles + register), without the optional feature.
- The table is read-only outside IDLE, so the result always reflects one consistent table.

Optional Feature:
Macro PLA_CUBE_SCHED_EARLY_EXIT_EN.
- Defined: SCAN leaves for DONE in the cycle of the first match. Latency = ptr_of_first_match+2 cycles. A miss still takes NCUBES+1 cycles.
- Undefined: all NCUBES entries are always scanned and latency is fixed.
- out_y/out_idx values are identical in both builds.

Test Plan:
- Reset then vector 12'h0E3 with empty table -> out_valid after 9 cycles, out_y=0, out_idx=0.
- Write entry 3 care=12'hFFF val=12'h0E3 en=1; send x=12'h0E3 -> out_y=1, out_idx=3. Send x=12'h0E2 -> out_y=0.
- Entries 2 and 5 both enabled with care=12'h000 -> any x gives out_y=1, out_idx=2. With EARLY_EXIT_EN, latency = 4 cycles.
- During SCAN: pulse cfg_we to entry 0, hold in_valid=1 and keep out_ready=0 for 5 cycles in DONE -> write is dropped (entry 0 unchanged), in_ready=0 throughout, out_y/out_idx stable, no second vector accepted until after the out handshake.
- Same-cycle cfg_we (entry 1 care=12'h001 val=12'h001 en=1) and in_valid with x=12'h001 in IDLE -> out_y=1, out_idx=1.
- Assert rst during SCAN cycle 4 -> out_valid stays 0, all entries disabled, in_ready=1 one cycle after rst release.
